// File: rtl/c3lib_rstsync_pkg.sv
// Shared types and sizing helpers for the c3lib reset synchronizer/sequencer.
// Optional scan support in the top is controlled by C3LIB_RSTSYNC_SCAN_EN.
package c3lib_rstsync_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    typedef enum logic [2:0] {
        RESET = 3'd0,
        HOLD  = 3'd1,
        RUN   = 3'd2,
        SOFT  = 3'd3,
        ACK   = 3'd4
    } state_t;

    function automatic int cnt_width(input int hold_cycles);
        int w;
        w = $clog2(hold_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/c3lib_rstsync_chain.sv
// De-assertion synchronizer: SYNC_STAGES flops shifting in tie-high, all
// cleared asynchronously by rst_n.
module c3lib_rstsync_chain
    import c3lib_rstsync_pkg::*;
#(
    parameter int SYNC_STAGES = 3
) (
    input  logic clk,
    input  logic rst_n,
    output logic sync_q
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
        $error("c3lib_rstsync_chain: SYNC_STAGES out of range");
    end

    logic                   tieh;
    logic [SYNC_STAGES-1:0] chain_q;

    c3lib_tieh_lcell u_tieh (
        .tieh (tieh)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain_q <= '0;
        else        chain_q <= {chain_q[SYNC_STAGES-2:0], tieh};
    end

    assign sync_q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/c3lib_tieh_lcell.sv
// Behavioural model of the library tie-high leaf cell.
module c3lib_tieh_lcell (
    output logic tieh
);

    assign tieh = 1'b1;

endmodule

// File: rtl/c3lib_rstsync_seq.sv
// Reset synchronizer and sequencer with a 4-phase soft-reset handshake.
// Define C3LIB_RSTSYNC_SCAN_EN to add scan_mode bypass of rst_n_out.
module c3lib_rstsync_seq
    import c3lib_rstsync_pkg::*;
#(
    parameter int SYNC_STAGES = 3,
    parameter int HOLD_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
`ifdef C3LIB_RSTSYNC_SCAN_EN
    input  logic scan_mode,
`endif
    input  logic soft_rst_req,
    output logic rst_n_out,
    output logic rst_done,
    output logic soft_rst_ack
);

    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("c3lib_rstsync_seq: HOLD_CYCLES must be >= 1");
    end

    localparam int             CNT_W    = cnt_width(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic             sync_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             done_q, done_d;
    logic             ack_q, ack_d;

    c3lib_rstsync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_chain (
        .clk    (clk),
        .rst_n  (rst_n),
        .sync_q (sync_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RESET: if (sync_q)              state_d = HOLD;
            HOLD:  if (cnt_q == CNT_LAST)   state_d = RUN;
            RUN:   if (soft_rst_req)        state_d = SOFT;
            SOFT:  if (cnt_q == CNT_LAST)   state_d = ACK;
            ACK:   if (!soft_rst_req)       state_d = RUN;
            default:                        state_d = RESET;
        endcase

        // Counter restarts on every state entry and saturates rather than wraps.
        cnt_d = cnt_q;
        if (state_d != state_q)
            cnt_d = '0;
        else if ((state_q == HOLD || state_q == SOFT) && cnt_q != CNT_LAST)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_comb begin
        out_d  = (state_d == RUN) || (state_d == ACK);
        done_d = done_q || (state_d == RUN);
        ack_d  = (state_d == ACK);
    end

`ifdef C3LIB_RSTSYNC_SCAN_EN
    assign rst_n_out    = scan_mode ? rst_n : out_q;
    assign rst_done     = done_q & ~scan_mode;
    assign soft_rst_ack = ack_q & ~scan_mode;
`else
    assign rst_n_out    = out_q;
    assign rst_done     = done_q;
    assign soft_rst_ack = ack_q;
`endif

endmodule

// File: tb/tb_c3lib_rstsync_seq.sv
// Scoreboard bench: default DUT plus a SYNC_STAGES=2/HOLD_CYCLES=1 DUT on a shared rst_n.
module tb_c3lib_rstsync_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic soft_rst_req = 1'b0;
    logic req2 = 1'b0;
    logic scan_mode = 1'b0;

    logic out1, done1, ack1;
    logic out2, done2, ack2;

    always #5 clk = ~clk;

    c3lib_rstsync_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef C3LIB_RSTSYNC_SCAN_EN
        .scan_mode    (scan_mode),
`endif
        .soft_rst_req (soft_rst_req),
        .rst_n_out    (out1),
        .rst_done     (done1),
        .soft_rst_ack (ack1)
    );

    c3lib_rstsync_seq #(.SYNC_STAGES(2), .HOLD_CYCLES(1)) dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef C3LIB_RSTSYNC_SCAN_EN
        .scan_mode    (scan_mode),
`endif
        .soft_rst_req (req2),
        .rst_n_out    (out2),
        .rst_done     (done2),
        .soft_rst_ack (ack2)
    );

    typedef struct {
        logic [5:0] v;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   k     = 0;   // rising edges since the last rst_n release

    // Monitor: one expectation per cycle, compared on the falling edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [5:0] got;
            e   = q.pop_front();
            got = {out1, done1, ack1, out2, done2, ack2};
            total++;
            if (got !== e.v) begin
                bad++;
                $display("FAIL %s: got out/done/ack/out2/done2/ack2=%b expected %b (t=%0t)",
                         e.nm, got, e.v, $time);
            end
        end
    end

    // mode: 0 plain edge, 1 assert rst_n after the edge, 2 sub-cycle rst_n pulse
    task automatic step(input logic req, input logic eo, input logic ed, input logic ea,
                        input int mode, input string nm);
        exp_t e;
        logic e2;
        soft_rst_req = req;
        @(posedge clk);
        #1;
        if (rst_n) k++;
        if (mode == 1) begin
            rst_n = 1'b0;
            k = 0;
            #1;
        end else if (mode == 2) begin
            rst_n = 1'b0;
            #1;
            rst_n = 1'b1;
            k = 0;
            #1;
        end
        e2   = scan_mode ? rst_n : (rst_n && k >= 4);
        e.v  = {eo, ed, ea, e2, (scan_mode ? 1'b0 : e2), 1'b0};
        e.nm = nm;
        q.push_back(e);
    endtask

    task automatic run(input int n, input logic req, input logic eo, input logic ed,
                       input logic ea, input string nm);
        for (int i = 0; i < n; i++) step(req, eo, ed, ea, 0, nm);
    endtask

    task automatic release_rst();
        rst_n = 1'b1;
        k = 0;
    endtask

    initial begin
        // power-on
        run(5, 0, 0, 0, 0, "reset_state");
        release_rst();
        run(19, 0, 0, 0, 0, "por_hold");
        step(0, 1, 1, 0, 0, "por_edge20");
        run(3, 0, 1, 1, 0, "run_idle");

        // soft reset, request held 10 cycles in ACK
        step(1, 0, 1, 0, 0, "soft_edge_e");
        run(15, 1, 0, 1, 0, "soft_low");
        step(1, 1, 1, 1, 0, "soft_ack_e16");
        run(10, 1, 1, 1, 1, "ack_held_no_retrigger");
        step(0, 1, 1, 0, 0, "ack_release");
        run(2, 0, 1, 1, 0, "run_idle2");

        // request dropped at SOFT cycle 3
        step(1, 0, 1, 0, 0, "drop_edge_e");
        run(2, 1, 0, 1, 0, "drop_soft_req_hi");
        run(13, 0, 0, 1, 0, "drop_soft_req_lo");
        step(0, 1, 1, 1, 0, "drop_ack_e16");
        step(0, 1, 1, 0, 0, "drop_ack_exit");
        run(2, 0, 1, 1, 0, "run_idle3");

        // asynchronous abort mid-SOFT
        step(1, 0, 1, 0, 0, "abort_soft_e");
        run(4, 1, 0, 1, 0, "abort_soft_low");
        step(1, 0, 0, 0, 1, "abort_soft_async");
        run(2, 0, 0, 0, 0, "abort_soft_held");
        release_rst();

        // asynchronous abort mid-HOLD (cnt=7), then full sequence
        run(10, 0, 0, 0, 0, "hold_before_abort");
        step(0, 0, 0, 0, 1, "abort_hold_async");
        run(1, 0, 0, 0, 0, "abort_hold_held");
        release_rst();
        run(19, 0, 0, 0, 0, "rerun_hold");
        step(0, 1, 1, 0, 0, "rerun_edge20");
        run(2, 0, 1, 1, 0, "rerun_idle");

        // sub-cycle rst_n pulse, then request high throughout the sequence
        step(0, 0, 0, 0, 2, "short_pulse");
        run(19, 1, 0, 0, 0, "req_ignored_early");
        step(1, 1, 1, 0, 0, "req_first_run_edge");
        step(1, 0, 1, 0, 0, "req_soft_start");
        run(15, 1, 0, 1, 0, "req_soft_low");
        step(1, 1, 1, 1, 0, "req_ack");
        step(0, 1, 1, 0, 0, "req_ack_release");
        run(2, 0, 1, 1, 0, "run_idle4");

`ifdef C3LIB_RSTSYNC_SCAN_EN
        scan_mode = 1'b1;
        step(0, 1, 0, 0, 0, "scan_rst_high");
        step(0, 0, 0, 0, 1, "scan_rst_low_async");
        run(1, 0, 0, 0, 0, "scan_rst_low");
        release_rst();
        step(0, 1, 0, 0, 0, "scan_follow_release");
        run(2, 0, 1, 0, 0, "scan_run");
`endif

        repeat (3) @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/c3lib_rstsync_seq.md
Name: c3lib_rstsync_seq

Overview:
Reset synchronizer and sequencer. It takes a raw asynchronous active-low reset and produces a clean reset for a clock domain. The output asserts asynchronously and de-asserts synchronously, after a programmable hold period. The synchronizer chain's data input is driven by a c3lib_tieh_lcell, so this block is the direct consumer of the tie-high cell. It also provides a 4-phase soft-reset handshake for local logic.

Parameters:
SYNC_STAGES, 3, number of flops in the de-assertion synchronizer chain (legal range 2..4)
HOLD_CYCLES, 16, cycles rst_n_out stays low after sync completes and during a soft reset (must be >= 1)

Ports:
clk  input  1  domain clock
rst_n  input  1  raw reset; asynchronous, active-low
soft_rst_req  input  1  soft-reset request level; synchronous to clk (caller synchronizes)
rst_n_out  output  1  sequenced reset for the domain; active-low
rst_done  output  1  power-on sequence complete; sticky until rst_n asserts
soft_rst_ack  output  1  soft-reset acknowledge level

Behaviour:
- Reset: one clock, clk. rst_n is asynchronous and active-low. While rst_n=0:
  - all flops clear immediately, including chain, FSM and counter;
  - rst_n_out=0, rst_done=0, soft_rst_ack=0;
  - state is RESET.
- Sync chain:
  - Flop D input is the c3lib_tieh_lcell output; each flop has async clear on rst_n.
  - Edge k means the k-th clk rising edge after rst_n de-asserts.
  - Chain output sync_q=1 from edge SYNC_STAGES.
- Counter: CNT_W = clog2(HOLD_CYCLES) bits, minimum 1. Cleared on every state entry. Never wraps; the terminal compare is cnt==HOLD_CYCLES-1.
- FSM states and transitions:
  - RESET -> HOLD when sync_q=1 is sampled (edge SYNC_STAGES+1); cnt=0.
  - HOLD: cnt increments each edge. On cnt==HOLD_CYCLES-1 -> RUN.
    - rst_n_out=1 and rst_done=1 are registered at edge SYNC_STAGES+1+HOLD_CYCLES.
  - RUN: soft_rst_req=1 sampled at edge e -> SOFT.
    - rst_n_out=0 registered at edge e.
  - SOFT: counts as in HOLD. At edge e+HOLD_CYCLES -> ACK, with rst_n_out=1 and soft_rst_ack=1.
  - ACK: holds soft_rst_ack=1 while soft_rst_req=1. When soft_rst_req=0 is sampled -> RUN, and soft_rst_ack=0 is registered that edge.
- All outputs are direct flop outputs, so they are glitch-free.
- Assertion is asynchronous: rst_n low at any time, any state, forces rst_n_out=0 with no clock required.
- Boundary conditions:
  - soft_rst_req high during RESET/HOLD: ignored. It is acted on only once RUN is reached, if still high.
  - soft_rst_req dropped during SOFT: SOFT still completes the full HOLD_CYCLES and enters ACK. ACK then exits on the next edge.
  - soft_rst_req held high in ACK: no retrigger. A new request requires req low, then high again in RUN.
  - rst_done stays 1 through SOFT and ACK; it clears only on rst_n.
  - rst_n pulse shorter than one clock period: still clears all state and restarts the full sequence.
- Unreachable state encodings return to RESET with rst_n_out=0.

Optional Feature:
C3LIB_RSTSYNC_SCAN_EN
- Defined:
  - adds input port scan_mode (1 bit);
  - when scan_mode=1, rst_n_out is driven combinationally by rst_n through a mux, for tester controllability;
  - rst_done and soft_rst_ack are forced to 0;
  - FSM, chain and counter behaviour are unchanged.
- Not defined: no scan_mode port; rst_n_out is always the flop output.

Decomposition:
- Package c3lib_rstsync_pkg:
  - state enum typedef with values RESET, HOLD, RUN, SOFT, ACK;
  - constant function computing counter width from HOLD_CYCLES;
  - SYNC_STAGES legal min/max constants.
- Sub-module c3lib_rstsync_chain:
  - parameterized SYNC_STAGES flop chain with async clear;
  - instantiates c3lib_tieh_lcell internally for its D input;
  - single output sync_q.
- Top level holds the FSM, counter, output flops and the optional scan mux.

Test Plan:
- Power-on, defaults: rst_n low 5 cycles, then high -> rst_n_out and rst_done rise at edge 20, not before; soft_rst_ack stays 0.
- SYNC_STAGES=2, HOLD_CYCLES=1: release rst_n -> rst_n_out=1 at edge 4.
- Soft reset in RUN: req=1 sampled at edge e -> rst_n_out=0 at edge e through e+15; rst_n_out=1 and ack=1 at edge e+16; req=0 sampled at edge f -> ack=0 at edge f; rst_done=1 throughout.
- Async abort: assert rst_n mid-HOLD (cnt=7) and mid-SOFT, asynchronously between edges -> all outputs 0 immediately; full 20-edge sequence repeats on release.
- Request edge cases:
  - req high from reset -> soft reset starts only at the first RUN edge;
  - req held high in ACK for 10 cycles -> no second SOFT;
  - req dropped at SOFT cycle 3 -> full 16 cycles low, then ACK for one edge.
- With C3LIB_RSTSYNC_SCAN_EN and scan_mode=1: toggle rst_n -> rst_n_out follows combinationally; rst_done=0 and soft_rst_ack=0.
